// File: rtl/kernel_stage0_pkg.sv
// Shared types and widths for the stage-0 tile address generator.
//   - FSM state encoding
//   - operand / product / column / address widths
//   - sideband record carried alongside the multiplier pipeline
package kernel_stage0_pkg;

  localparam int HEAD_W   = 5;
  localparam int STRIDE_W = 14;
  localparam int PROD_W   = 19;
  localparam int COL_W    = 8;
  localparam int ADDR_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Travels with each issued product so the add stage knows which column
  // offset to apply and whether this is the final address of the job.
  typedef struct packed {
    logic [COL_W-1:0] col;
    logic             last;
  } sideband_t;

endpackage

// File: rtl/kernel_stage0_tile_addr_gen_mul.sv
// Stage-0 4-stage unsigned 5x14 -> 19 multiplier primitive.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   ce_i    clock enable; all stages hold when low
//   a_i     5-bit multiplicand (head index)
//   b_i     14-bit multiplier (row stride)
//   p_o     19-bit product, valid 4 enabled cycles after a_i/b_i are captured
module kernel_stage0_tile_addr_gen_mul
  import kernel_stage0_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ce_i,
  input  logic [HEAD_W-1:0]   a_i,
  input  logic [STRIDE_W-1:0] b_i,
  output logic [PROD_W-1:0]   p_o
);

  logic [HEAD_W-1:0]   a_q;
  logic [STRIDE_W-1:0] b_q;
  logic [PROD_W-1:0]   p2_q;
  logic [PROD_W-1:0]   p3_q;
  logic [PROD_W-1:0]   p4_q;
  logic [PROD_W-1:0]   prod_d;

  // 31 * 16383 < 2^19, so the zero-extended product never overflows.
  assign prod_d = PROD_W'(a_q) * PROD_W'(b_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q  <= '0;
      b_q  <= '0;
      p2_q <= '0;
      p3_q <= '0;
      p4_q <= '0;
    end else if (ce_i) begin
      a_q  <= a_i;
      b_q  <= b_i;
      p2_q <= prod_d;
      p3_q <= p2_q;
      p4_q <= p3_q;
    end
  end

  assign p_o = p4_q;

endmodule

// File: rtl/kernel_stage0_tile_addr_gen.sv
// Stage-0 tile address generator.
// Walks heads x columns, issues head*stride into the 4-stage multiplier and
// emits base + product + column as a valid/ready address stream.
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   start                   job request, accepted only in IDLE
//   cfg_heads/stride/cols/base  job configuration, latched on accepted start
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse at job end
//   out_valid/out_ready     output handshake
//   out_addr, out_last      address and final-address marker
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing one (head, column) pair per enabled cycle
// ST_DRAIN | all issued; waiting for the pipe to empty and last handshake
// ST_DONE  | job finished; done pulses, then back to IDLE
module kernel_stage0_tile_addr_gen #(
  parameter int MUL_LAT = 4,   // must match the multiplier primitive depth
  parameter int ADDR_W  = 20
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [4:0]        cfg_heads,
  input  logic [13:0]       cfg_stride,
  input  logic [7:0]        cfg_cols,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  import kernel_stage0_pkg::*;

  state_e              state_q;
  logic [HEAD_W-1:0]   heads_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [COL_W-1:0]    cols_q;
  logic [ADDR_W-1:0]   base_q;
  logic [HEAD_W-1:0]   h_q;
  logic [COL_W-1:0]    c_q;
  logic                busy_q;
  logic                done_q;

  logic [MUL_LAT-1:0]  pipe_v_q;
  sideband_t           pipe_sb_q [MUL_LAT];

  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_last_q;

  logic                ce;
  logic                issue;
  logic                col_wrap;
  logic                last_iss;
  sideband_t           issue_sb;
  sideband_t           head_sb;
  logic [PROD_W-1:0]   prod;
  logic [ADDR_W-1:0]   out_addr_d;

  // Everything upstream of the output register freezes only while a valid
  // address is being held against a stalled consumer.
  assign ce       = !(out_valid_q && !out_ready);
  assign issue    = (state_q == ST_RUN) && ce;
  assign col_wrap = (c_q == cols_q - 8'd1);
  assign last_iss = col_wrap && (h_q == heads_q - 5'd1);

  assign issue_sb.col  = c_q;
  assign issue_sb.last = last_iss;

  kernel_stage0_tile_addr_gen_mul u_mul (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .ce_i   (ce),
    .a_i    (h_q),
    .b_i    (stride_q),
    .p_o    (prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= ST_IDLE;
      heads_q  <= '0;
      stride_q <= '0;
      cols_q   <= '0;
      base_q   <= '0;
      h_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // done is the registered image of the DONE state, so it lands the
      // cycle after DONE is entered and lasts exactly one cycle.
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            heads_q  <= cfg_heads;
            stride_q <= cfg_stride;
            cols_q   <= cfg_cols;
            base_q   <= cfg_base;
            h_q      <= '0;
            c_q      <= '0;
            busy_q   <= 1'b1;
            if ((cfg_heads == 5'd0) || (cfg_cols == 8'd0)) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (ce) begin
            if (last_iss) begin
              state_q <= ST_DRAIN;
            end else if (col_wrap) begin
              c_q <= '0;
              h_q <= h_q + 5'd1;
            end else begin
              c_q <= c_q + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          if ((pipe_v_q == '0) && out_valid_q && out_ready && out_last_q) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sideband delay line, aligned stage-for-stage with the multiplier.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pipe_v_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_sb_q[i] <= '0;
      end
    end else if (ce) begin
      pipe_v_q     <= {pipe_v_q[MUL_LAT-2:0], issue};
      pipe_sb_q[0] <= issue_sb;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_sb_q[i] <= pipe_sb_q[i-1];
      end
    end
  end

  assign head_sb    = pipe_sb_q[MUL_LAT-1];
  assign out_addr_d = base_q + ADDR_W'(prod) + ADDR_W'(head_sb.col);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (ce) begin
      out_valid_q <= pipe_v_q[MUL_LAT-1];
      out_last_q  <= pipe_v_q[MUL_LAT-1] && head_sb.last;
      if (pipe_v_q[MUL_LAT-1]) begin
        out_addr_q <= out_addr_d;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/kernel_stage0_tile_addr_gen.md
Name: kernel_stage0_tile_addr_gen

Overview:
- Address generator directly upstream of the stage-0 4-stage unsigned 5×14→19 multiplier.
- Walks a (head, column) loop nest and issues head index × row stride into the multiplier.
- Adds the tile base address and column offset to each product.
- Emits a stream of 20-bit buffer addresses under valid/ready backpressure. Feeds the stage-0 memory read port.

Parameters:
- MUL_LAT, 4, multiplier pipeline depth in cycles; the sideband delay line matches it.
- ADDR_W, 20, output address width; sums wrap modulo 2^ADDR_W.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- cfg_heads  in  5  head count (0..31); sampled on accepted start
- cfg_stride  in  14  row stride in words; sampled on accepted start
- cfg_cols  in  8  columns per head (0..255); sampled on accepted start
- cfg_base  in  20  tile base address; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- out_valid  out  1  address valid
- out_ready  in  1  consumer ready
- out_addr  out  20  base + h*stride + c
- out_last  out  1  marks the final address of the job

Behaviour:
- Reset: busy, done, out_valid and out_last are 0; out_addr is 0; FSM is IDLE; valid and sideband pipes are cleared.
- Reset mid-job aborts immediately. No done pulse is produced.
- Global ce = !(out_valid && !out_ready). ce drives the multiplier ce, the valid/sideband shift registers, the output register and the issue counters.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN: on start with cfg_heads≠0 and cfg_cols≠0. Config is latched; h=0, c=0.
  - IDLE → DONE: on start with cfg_heads=0 or cfg_cols=0. No addresses are issued.
  - RUN: each cycle with ce=1 issues (a=h, b=stride) to the multiplier and pushes {c, last} into the MUL_LAT-deep sideband pipe.
    - c increments each issue; at c=cols-1 it wraps to 0 and h increments.
    - last = (h=heads-1 && c=cols-1).
    - After the last issue: → DRAIN.
  - DRAIN: ce-gated pipe advance continues. → DONE when the pipe valid bits are all 0 and the output handshake of the last address has completed (out_valid && out_ready && out_last).
  - DONE: done=1 for one cycle, then → IDLE.
- start outside IDLE is ignored. The latched config is unaffected by later cfg changes.
- Latency: with out_ready held high, the first issue occurs the cycle after start is accepted.
- out_valid asserts MUL_LAT+1 cycles after issue: MUL_LAT multiplier stages plus one registered add stage.
- Throughput: 1 address/cycle.
- Output add stage, on ce: out_addr ← (cfg_base + product[18:0] + c) mod 2^20. Operands are zero-extended.
- Maximum product = 30*16383 = 491490; it fits 19 bits.
- Backpressure: out_valid, out_addr and out_last hold stable while out_valid && !out_ready. All upstream stages freeze, the multiplier included via ce, so no data is lost or duplicated.
- Empty bubbles (valid=0) propagate normally. When the output register is empty, ce=1 regardless of out_ready.

Decomposition:
- Shared package kernel_stage0_pkg holds:
  - the FSM state enum;
  - the width constants HEAD_W=5, STRIDE_W=14, PROD_W=19, COL_W=8, ADDR_W=20;
  - the sideband struct {col[7:0], last}.
- One sub-module instance: the existing stage-0 4-stage unsigned 5×14→19 multiplier primitive, driven with ce as above.
- The delay line is local RTL: a MUL_LAT-deep valid/sideband shift register.

Test Plan:
- Basic job: heads=2, stride=100, cols=3, base=0x01000, out_ready=1.
  - Required: out_addr 0x01000, 0x01001, 0x01002, 0x01064, 0x01065, 0x01066 on consecutive cycles.
  - First valid 6 cycles after start; out_last only on 0x01066; single done pulse afterwards.
- Backpressure: same job with out_ready toggled 1,0,0,1,... (pattern repeats).
  - Required: identical six-address sequence, each held stable while stalled; no drops or duplicates.
- Wrap-around: heads=1, stride=1, cols=2, base=0xFFFFF.
  - Required: 0xFFFFF then 0x00000 (last=1).
- Max product: heads=31, stride=16383, cols=1, base=0.
  - Required: final address 491490 with last=1; 31 addresses total.
- Zero work: cfg_cols=0 (and separately cfg_heads=0).
  - Required: no out_valid; done pulses 2 cycles after start; busy high only in between.
- Async reset mid-job and start while busy:
  - ap_rst_n low during RUN: all outputs 0 immediately, no done; a new job after release runs cleanly.
  - start pulsed during RUN: ignored, original sequence unchanged.
